// File: rtl/ram_rd_check.sv
// rtl/ram_rd_check.sv - read-side pattern checker for the on-chip RAM test driver
//
// Purpose: passively watches the RAM driver's read strobe, address and the RAM
// read data. It checks every returned word against mem[a] = a + DATA_OFFSET and
// reports the outcome of each read burst of up to 2^ADDR_W words.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ram_rd_en    read enable from the RAM driver
//   ram_addr     read address from the RAM driver
//   ram_rd_data  RAM read data, valid RD_LATENCY cycles after ram_rd_en
//   chk_done     one-cycle pulse when a burst result is published
//   chk_pass     last burst had no mismatches and was full length
//   err_cnt      mismatches in last burst, saturating at 255
//   err_addr     address of first mismatch in last burst, 0 if none
//   err_sticky   set by any failed burst, cleared only by reset
//   burst_len    words checked in last burst
module ram_rd_check #(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int RD_LATENCY  = 1,
  parameter int DATA_OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_rd_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_sticky,
  output logic [ADDR_W:0]   burst_len
);

  localparam logic [ADDR_W:0]   DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] OFFSET    = DATA_W'(DATA_OFFSET);

  typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;
  state_t state;

  // Alignment pipeline: strobe and address travel alongside the RAM access so
  // that vld_d/addr_d line up with the data they requested.
  logic              vld_pipe  [RD_LATENCY];
  logic [ADDR_W-1:0] addr_pipe [RD_LATENCY];
  logic              vld_d;
  logic [ADDR_W-1:0] addr_d;

  assign vld_d  = vld_pipe[RD_LATENCY-1];
  assign addr_d = addr_pipe[RD_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= 1'b0;
        addr_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= ram_rd_en;
      addr_pipe[0] <= ram_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  logic [DATA_W-1:0] exp_data;
  logic              mismatch;

  assign exp_data = DATA_W'(addr_d) + OFFSET;
  assign mismatch = vld_d && (ram_rd_data != exp_data);

  // Burst accumulators for the burst currently open.
  logic [ADDR_W:0]   word_cnt;
  logic [7:0]        errors;
  logic [ADDR_W-1:0] first_addr;

  // Next accumulator values if the word in this cycle is compared. Only an
  // open burst (CHECK) carries history; from IDLE or REPORT the word starts a
  // fresh burst.
  logic              cont;
  logic              had_err;
  logic [ADDR_W:0]   words_nxt;
  logic [7:0]        errs_base;
  logic [7:0]        errs_nxt;
  logic [ADDR_W-1:0] first_nxt;

  // Totals of the burst as of the end of this cycle, and whether it ends here.
  logic [ADDR_W:0]   tot_words;
  logic [7:0]        tot_errs;
  logic [ADDR_W-1:0] tot_first;
  logic              burst_end;
  logic              pass_now;

  always_comb begin
    cont      = (state == CHECK);
    words_nxt = cont ? word_cnt + 1'b1 : ONE_CNT;
    errs_base = cont ? errors : 8'd0;
    errs_nxt  = (mismatch && errs_base != 8'hFF) ? errs_base + 8'd1 : errs_base;
    // errors saturates instead of wrapping, so nonzero means a mismatch was seen
    had_err   = cont && (errors != 8'd0);
    first_nxt = had_err ? first_addr : (mismatch ? addr_d : '0);

    tot_words = vld_d ? words_nxt : word_cnt;
    tot_errs  = vld_d ? errs_nxt  : errors;
    tot_first = vld_d ? first_nxt : first_addr;

    // A burst closes when the strobe drops or when the last word of a full
    // depth has just been compared.
    burst_end = vld_d ? (words_nxt == DEPTH_CNT) : cont;
    pass_now  = (tot_errs == 8'd0) && (tot_words == DEPTH_CNT);
  end

  // Results are registered on the edge that enters REPORT, so chk_done and the
  // result outputs are visible during the REPORT cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      errors     <= '0;
      first_addr <= '0;
      chk_done   <= 1'b0;
      chk_pass   <= 1'b0;
      err_cnt    <= '0;
      err_addr   <= '0;
      err_sticky <= 1'b0;
      burst_len  <= '0;
    end else begin
      chk_done <= 1'b0;
      if (vld_d) begin
        word_cnt   <= words_nxt;
        errors     <= errs_nxt;
        first_addr <= first_nxt;
      end
      if (burst_end) begin
        state      <= REPORT;
        chk_done   <= 1'b1;
        chk_pass   <= pass_now;
        err_cnt    <= tot_errs;
        err_addr   <= tot_first;
        burst_len  <= tot_words;
        err_sticky <= err_sticky | ~pass_now;
      end else if (vld_d) begin
        state <= CHECK;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_check.sv
// tb/tb_ram_rd_check.sv - testbench for ram_rd_check
module tb_ram_rd_check;

  localparam int NI   = 3;
  localparam int NMAX = 1200;

  int aw_t  [NI] = '{5, 5, 9};
  int lat_t [NI] = '{1, 2, 1};
  int off_t [NI] = '{0, 64, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cur_en;
  logic [8:0] cur_addr;
  logic [7:0] cur_data;
  int         sel;

  always #5 clk = ~clk;

  logic       en0, en1, en2;
  logic       d0_done, d0_pass, d0_sticky, d1_done, d1_pass, d1_sticky, d2_done, d2_pass, d2_sticky;
  logic [7:0] d0_cnt, d1_cnt, d2_cnt;
  logic [4:0] d0_eaddr, d1_eaddr;
  logic [8:0] d2_eaddr;
  logic [5:0] d0_len, d1_len;
  logic [9:0] d2_len;

  assign en0 = cur_en && (sel == 0);
  assign en1 = cur_en && (sel == 1);
  assign en2 = cur_en && (sel == 2);

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(1), .DATA_OFFSET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ram_rd_en(en0), .ram_addr(cur_addr[4:0]), .ram_rd_data(cur_data),
    .chk_done(d0_done), .chk_pass(d0_pass), .err_cnt(d0_cnt), .err_addr(d0_eaddr),
    .err_sticky(d0_sticky), .burst_len(d0_len));

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LATENCY(2), .DATA_OFFSET(8'h40)) dut1 (
    .clk(clk), .rst_n(rst_n), .ram_rd_en(en1), .ram_addr(cur_addr[4:0]), .ram_rd_data(cur_data),
    .chk_done(d1_done), .chk_pass(d1_pass), .err_cnt(d1_cnt), .err_addr(d1_eaddr),
    .err_sticky(d1_sticky), .burst_len(d1_len));

  ram_rd_check #(.ADDR_W(9), .DATA_W(8), .RD_LATENCY(1), .DATA_OFFSET(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ram_rd_en(en2), .ram_addr(cur_addr), .ram_rd_data(cur_data),
    .chk_done(d2_done), .chk_pass(d2_pass), .err_cnt(d2_cnt), .err_addr(d2_eaddr),
    .err_sticky(d2_sticky), .burst_len(d2_len));

  logic       o_done, o_pass, o_sticky;
  logic [7:0] o_cnt;
  logic [8:0] o_eaddr;
  logic [9:0] o_len;

  always_comb begin
    o_done = 1'b0; o_pass = 1'b0; o_sticky = 1'b0; o_cnt = '0; o_eaddr = '0; o_len = '0;
    case (sel)
      0: begin o_done = d0_done; o_pass = d0_pass; o_sticky = d0_sticky; o_cnt = d0_cnt;
               o_eaddr = {4'b0, d0_eaddr}; o_len = {4'b0, d0_len}; end
      1: begin o_done = d1_done; o_pass = d1_pass; o_sticky = d1_sticky; o_cnt = d1_cnt;
               o_eaddr = {4'b0, d1_eaddr}; o_len = {4'b0, d1_len}; end
      default: begin o_done = d2_done; o_pass = d2_pass; o_sticky = d2_sticky; o_cnt = d2_cnt;
               o_eaddr = d2_eaddr; o_len = d2_len; end
    endcase
  end

  // Per-cycle stimulus schedule: strobe, address and the data on the RAM bus.
  logic       en_a   [NMAX+8];
  logic [8:0] addr_a [NMAX+8];
  logic [7:0] data_a [NMAX+8];

  typedef struct { int cyc; int pass; int cnt; int eaddr; int len; int sticky; } rep_t;
  rep_t obs_q[$];
  rep_t exp_q[$];
  int   msticky [NI];

  typedef struct {
    int inst; int nrd; int bad_a; int bad_v; int dlat; int stuck;
    int e_pass; int e_cnt; int e_addr; int e_len; int e_sticky;
  } vec_t;
  vec_t tbl [7];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear(input int rnd);
    for (int c = 0; c < NMAX + 8; c++) begin
      en_a[c]   = 1'b0;
      addr_a[c] = '0;
      data_a[c] = (rnd != 0) ? 8'($urandom) : 8'hFF;
    end
  endtask

  // One contiguous read run; the RAM answers dlat cycles after each read.
  task automatic add_run(input int inst, input int start, input int n, input int a0, input int dlat,
                         input int bad_a, input int bad_v, input int stuck, input int rnd_err);
    int depth;
    depth = 1 << aw_t[inst];
    for (int k = 0; k < n; k++) begin
      int c;
      int a;
      c = start + k;
      a = (a0 + k) % depth;
      en_a[c]   = 1'b1;
      addr_a[c] = 9'(a);
      if (stuck != 0)                                       data_a[c+dlat] = 8'h00;
      else if (a == bad_a)                                  data_a[c+dlat] = 8'(bad_v);
      else if (rnd_err != 0 && $urandom_range(0, 7) == 0)   data_a[c+dlat] = 8'($urandom);
      else                                                  data_a[c+dlat] = 8'(a + off_t[inst]);
    end
  endtask

  task automatic play(input int inst, input int n);
    rep_t r;
    sel = inst;
    obs_q.delete();
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      cur_en = en_a[s]; cur_addr = addr_a[s]; cur_data = data_a[s];
      @(posedge clk);
      #1;
      if (o_done) begin
        r.cyc = s; r.pass = int'(o_pass); r.cnt = int'(o_cnt); r.eaddr = int'(o_eaddr);
        r.len = int'(o_len); r.sticky = int'(o_sticky);
        obs_q.push_back(r);
      end
    end
    @(negedge clk);
    cur_en = 1'b0;
  endtask

  task automatic emit(input int inst, input int cyc, input int len, input int errs, input int fa,
                      input int depth);
    rep_t r;
    r.cyc = cyc; r.len = len; r.cnt = errs; r.eaddr = fa;
    r.pass = (errs == 0 && len == depth) ? 1 : 0;
    if (r.pass == 0) msticky[inst] = 1;
    r.sticky = msticky[inst];
    exp_q.push_back(r);
  endtask

  // Reference: a read at cycle c is judged against the bus data at c+latency.
  // Contiguous reads form a burst, cut every 2^ADDR_W words. A full burst is
  // reported latency cycles after its last read, a short one a cycle later.
  task automatic model(input int inst, input int n);
    int depth, L, len, errs, fa;
    logic [7:0] ev;
    depth = 1 << aw_t[inst]; L = lat_t[inst]; len = 0; errs = 0; fa = 0;
    exp_q.delete();
    for (int c = 0; c < n; c++) begin
      if (en_a[c]) begin
        ev = 8'(int'(addr_a[c]) + off_t[inst]);
        len++;
        if (data_a[c+L] != ev) begin
          if (errs == 0) fa = int'(addr_a[c]);
          errs = (errs < 255) ? errs + 1 : 255;
        end
        if (len == depth) begin
          emit(inst, c + L, len, errs, fa, depth);
          len = 0; errs = 0; fa = 0;
        end
      end else if (len > 0) begin
        emit(inst, c + L, len, errs, fa, depth);
        len = 0; errs = 0; fa = 0;
      end
    end
  endtask

  task automatic cmp_q(input string tag);
    chk({tag, "_nrep"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_r%0d_cyc", tag, i),    obs_q[i].cyc,    exp_q[i].cyc);
      chk($sformatf("%s_r%0d_pass", tag, i),   obs_q[i].pass,   exp_q[i].pass);
      chk($sformatf("%s_r%0d_cnt", tag, i),    obs_q[i].cnt,    exp_q[i].cnt);
      chk($sformatf("%s_r%0d_eaddr", tag, i),  obs_q[i].eaddr,  exp_q[i].eaddr);
      chk($sformatf("%s_r%0d_len", tag, i),    obs_q[i].len,    exp_q[i].len);
      chk($sformatf("%s_r%0d_sticky", tag, i), obs_q[i].sticky, exp_q[i].sticky);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            inst nrd  bad  val dlat stk  pass cnt addr len sticky
    tbl[0] = '{0,  32,  -1,  0,   1,   0,   1,   0,   0,  32,  0};
    tbl[1] = '{0,  32,  13,  255, 1,   0,   0,   1,   13, 32,  1};
    tbl[2] = '{0,  32,  -1,  0,   1,   0,   1,   0,   0,  32,  1};
    tbl[3] = '{0,  20,  -1,  0,   1,   0,   0,   0,   0,  20,  1};
    tbl[4] = '{1,  32,  -1,  0,   2,   0,   1,   0,   0,  32,  0};
    tbl[5] = '{1,  32,  -1,  0,   1,   0,   0,   32,  0,  32,  1};
    tbl[6] = '{2,  512, -1,  0,   1,   1,   0,   255, 1,  512, 1};

    rst_n = 1'b0; cur_en = 1'b0; cur_addr = '0; cur_data = '0; sel = 0;
    for (int i = 0; i < NI; i++) msticky[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      sel = i;
      #1;
      chk($sformatf("reset_done_%0d", i),   int'(o_done),   0);
      chk($sformatf("reset_pass_%0d", i),   int'(o_pass),   0);
      chk($sformatf("reset_cnt_%0d", i),    int'(o_cnt),    0);
      chk($sformatf("reset_eaddr_%0d", i),  int'(o_eaddr),  0);
      chk($sformatf("reset_sticky_%0d", i), int'(o_sticky), 0);
      chk($sformatf("reset_len_%0d", i),    int'(o_len),    0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      int inst, depth, ecyc, n;
      inst  = tbl[i].inst;
      depth = 1 << aw_t[inst];
      n     = tbl[i].nrd + 10;
      clear(0);
      add_run(inst, 2, tbl[i].nrd, 0, tbl[i].dlat, tbl[i].bad_a, tbl[i].bad_v, tbl[i].stuck, 0);
      play(inst, n);
      model(inst, n);
      ecyc = 2 + tbl[i].nrd - 1 + lat_t[inst] + ((tbl[i].nrd < depth) ? 1 : 0);
      chk($sformatf("tbl%0d_nrep", i), obs_q.size(), 1);
      if (obs_q.size() > 0) begin
        chk($sformatf("tbl%0d_cyc", i),    obs_q[0].cyc,    ecyc);
        chk($sformatf("tbl%0d_pass", i),   obs_q[0].pass,   tbl[i].e_pass);
        chk($sformatf("tbl%0d_cnt", i),    obs_q[0].cnt,    tbl[i].e_cnt);
        chk($sformatf("tbl%0d_eaddr", i),  obs_q[0].eaddr,  tbl[i].e_addr);
        chk($sformatf("tbl%0d_len", i),    obs_q[0].len,    tbl[i].e_len);
        chk($sformatf("tbl%0d_sticky", i), obs_q[0].sticky, tbl[i].e_sticky);
      end
    end

    // Continuous strobe over two depths: two back-to-back bursts.
    clear(0);
    add_run(0, 2, 64, 0, 1, -1, 0, 0, 0);
    play(0, 74);
    model(0, 74);
    cmp_q("cont");
    chk("cont_nrep2", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("cont_spacing", obs_q[1].cyc - obs_q[0].cyc, 32);
      chk("cont_len0", obs_q[0].len, 32);
      chk("cont_len1", obs_q[1].len, 32);
    end

    // Reset after 10 reads of a burst; outputs currently hold nonzero results.
    sel = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cur_en = 1'b1; cur_addr = 9'(k); cur_data = 8'(k - 1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done",   int'(o_done),   0);
    chk("midrst_pass",   int'(o_pass),   0);
    chk("midrst_cnt",    int'(o_cnt),    0);
    chk("midrst_eaddr",  int'(o_eaddr),  0);
    chk("midrst_sticky", int'(o_sticky), 0);
    chk("midrst_len",    int'(o_len),    0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("midrst_hold_done%0d", k), int'(o_done), 0);
    end
    @(negedge clk);
    cur_en = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < NI; i++) msticky[i] = 0;
    clear(0);
    add_run(0, 2, 32, 0, 1, -1, 0, 0, 0);
    play(0, 42);
    model(0, 42);
    cmp_q("postrst");
    if (obs_q.size() > 0) chk("postrst_pass", obs_q[0].pass, 1);

    // Randomized bursts against the reference model.
    for (int it = 0; it < 40; it++) begin
      int inst, pos, nr, len, a0, dl;
      inst = $urandom_range(0, 2);
      clear(1);
      pos = 1 + $urandom_range(0, 2);
      nr  = $urandom_range(1, 4);
      for (int r = 0; r < nr; r++) begin
        len = $urandom_range(1, 80);
        a0  = $urandom_range(0, (1 << aw_t[inst]) - 1);
        dl  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : lat_t[inst];
        add_run(inst, pos, len, a0, dl, -1, 0, 0, 1);
        pos += len + $urandom_range(0, 3);
      end
      play(inst, pos + 6);
      model(inst, pos + 6);
      cmp_q($sformatf("rnd%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ram_rd_check.md
Name: ram_rd_check

Overview:
- Read-side companion to the on-chip RAM test driver. Passively monitors the driver's read strobe, address and RAM read data.
- Checks each returned byte against the written pattern mem[a] = a + DATA_OFFSET (mod 256).
- Reports per-burst pass/fail, error count and first failing address. Drives LEDs/ILA probes in the RAM demo top level.

Parameters:
- ADDR_W, 5, RAM address width; burst depth is 2^ADDR_W words (32).
- DATA_W, 8, RAM data width.
- RD_LATENCY, 1, clock cycles from ram_rd_en/ram_addr sampled to ram_rd_data valid; legal range 1..3.
- DATA_OFFSET, 0, pattern offset added to address to form expected data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ram_rd_en  in  1  read enable from RAM driver
- ram_addr  in  ADDR_W  read address from RAM driver
- ram_rd_data  in  DATA_W  RAM read data
- chk_done  out  1  one-cycle pulse at end of each read burst
- chk_pass  out  1  result of last completed burst (1 = all words matched, full length)
- err_cnt  out  8  mismatches in last completed burst, saturating at 255
- err_addr  out  ADDR_W  address of first mismatch in last completed burst; 0 if none
- err_sticky  out  1  set on any failed burst since reset; cleared only by reset
- burst_len  out  ADDR_W+1  words checked in last completed burst

Behaviour:
- Reset: one clock; rst_n asynchronous, active-low. All outputs 0, FSM in IDLE, alignment pipeline cleared.
- Alignment pipeline:
  - ram_rd_en and ram_addr are delayed RD_LATENCY registers, giving vld_d and addr_d.
  - The compare occurs in the cycle where vld_d=1, using ram_rd_data against expected = addr_d + DATA_OFFSET, truncated to DATA_W.
- FSM IDLE -> CHECK:
  - Transition on first cycle with vld_d=1. That word is compared in the same cycle.
  - Internal counters start fresh: word_cnt=1, errors=0|1, first-error latch.
- CHECK:
  - Each vld_d=1 cycle increments word_cnt and compares.
  - On mismatch: internal error count +1, saturating at 255. The first mismatch latches addr_d.
- CHECK -> REPORT:
  - Taken when vld_d=0, i.e. the burst ended.
  - Also taken when word_cnt reaches 2^ADDR_W and the current word has been compared.
  - Reads beyond 2^ADDR_W in one contiguous strobe start a new burst: REPORT -> CHECK directly if vld_d=1 in the REPORT cycle.
- REPORT (one cycle):
  - chk_done=1.
  - Outputs updated from internal counters: err_cnt, err_addr, burst_len=word_cnt.
  - chk_pass = (errors==0) && (word_cnt==2^ADDR_W). A short burst fails even with no data errors.
  - err_sticky |= ~chk_pass.
  - Next state is IDLE, or CHECK if vld_d=1. In that case the new burst's first word is compared this cycle.
- Result outputs hold until the next REPORT. chk_done is 0 outside REPORT.
- Address ordering is not checked; expected data is derived from the delayed address only.
- ram_rd_en during reset is ignored. Pipeline contents flush and no partial burst is reported.
- Reset mid-burst: accumulated state is discarded and outputs return to 0.

Test Plan:
- Nominal: write mem[a]=a, then read a=0..31 with RD_LATENCY=1.
  - Expect one chk_done pulse 1 cycle after the last data.
  - Expect chk_pass=1, err_cnt=0, err_addr=0, burst_len=32, err_sticky=0.
- Single corruption: RAM returns 8'hFF at a=13 only.
  - Expect chk_pass=0, err_cnt=1, err_addr=13, err_sticky=1.
  - A following clean burst gives chk_pass=1 while err_sticky stays 1.
- Short burst: ram_rd_en high for 20 reads (a=0..19), all correct.
  - Expect burst_len=20, chk_pass=0, err_cnt=0.
- Latency/offset: RD_LATENCY=2, DATA_OFFSET=8'h40, RAM returns a+0x40 two cycles after each read.
  - Expect chk_pass=1.
  - Driving data with latency 1 instead gives err_cnt=32 (every word misaligned), chk_pass=0.
- Continuous strobe and saturation: ram_rd_en held high for 64 cycles.
  - Expect two chk_done pulses 32 cycles apart, each burst_len=32.
  - Stuck-at-0 data over >255 errors is not reachable at depth 32; verify saturation with ADDR_W=9, stuck-at data → err_cnt=255.
- Reset mid-burst: assert rst_n=0 after 10 reads.
  - Expect all outputs 0 immediately, with no chk_done.
  - A full clean burst after release gives chk_pass=1.
